// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and 8N1 frame constants
// used by both the receive and transmit halves of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK_WAIT
  } uart_rx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_START_BITS = 1;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_FRAME_BITS = UART_START_BITS + UART_DATA_BITS + UART_STOP_BITS;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side handshake of the UART receiver: received byte, status pulses
// and the consumer's acknowledge.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rdata;
  logic                      rx_valid;
  logic                      rd_ack;
  logic                      frame_err;
  logic                      overrun;
  logic                      rx_busy;

  // Receiver side: produces data and status
  modport master (
    output rdata,
    output rx_valid,
    output frame_err,
    output overrun,
    output rx_busy,
    input  rd_ack
  );

  // Consumer side: reads data and acknowledges
  modport slave (
    input  rdata,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  rx_busy,
    output rd_ack
  );

endinterface

// File: rtl/uart_sync.sv
// N-flop synchroniser for an asynchronous input. Resets to 1 so an idle-high
// line does not look like a falling edge when reset is released.
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_reg;

  // Shift the raw input through N flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[N-2:0], d};
    end
  end

  assign q = sync_reg[N-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, mid-bit sampling with CLKS_PER_BIT clocks per bit.
// Reports received bytes as a held level plus frame-error / overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  uart_rx_if.master  bus
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST      = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t            state_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [2:0]                idx_reg;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] rdata_reg;
  logic                      rx_valid_reg;
  logic                      frame_err_reg;
  logic                      overrun_reg;
  logic                      rx_busy_reg;

  uart_sync #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  // Frame FSM: start validation, data shifting, stop check, break hold-off
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      rdata_reg     <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      rx_busy_reg   <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      // An ack clears the level; a byte completing in the same cycle wins below
      if (bus.rd_ack) begin
        rx_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (rx_s == UART_START_LEVEL) begin
            state_reg   <= START;
            cnt_reg     <= '0;
            rx_busy_reg <= 1'b1;
          end
        end

        START: begin
          if (cnt_reg == CNT_HALF_LAST) begin
            if (rx_s != UART_START_LEVEL) begin
              // Too short to be a start bit: treat as a glitch
              state_reg   <= IDLE;
              rx_busy_reg <= 1'b0;
            end else begin
              state_reg <= DATA;
              cnt_reg   <= '0;
              idx_reg   <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (cnt_reg == CNT_BIT_LAST) begin
            shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
            cnt_reg   <= '0;
            if (idx_reg == IDX_LAST) begin
              state_reg <= STOP;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        STOP: begin
          if (cnt_reg == CNT_BIT_LAST) begin
            cnt_reg <= '0;
            if (rx_s == UART_STOP_LEVEL) begin
              rdata_reg    <= shift_reg;
              rx_valid_reg <= 1'b1;
              overrun_reg  <= rx_valid_reg && !bus.rd_ack;
              state_reg    <= IDLE;
              rx_busy_reg  <= 1'b0;
            end else begin
              // Keep the last good byte; wait for the line to recover
              frame_err_reg <= 1'b1;
              state_reg     <= BRK_WAIT;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        BRK_WAIT: begin
          if (rx_s == UART_IDLE_LEVEL) begin
            state_reg   <= IDLE;
            rx_busy_reg <= 1'b0;
          end
        end

        default: begin
          state_reg   <= IDLE;
          rx_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata     = rdata_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.rx_busy   = rx_busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed and random 8N1 frames checked against a
// reference model that decodes the line waveform from the sampling points.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB       = 16;
  localparam int SYNC      = 2;
  localparam int HALF      = CPB / 2;
  // Ticks from the pin falling to the cycle holding the stop sample
  localparam int STOP_TICK = SYNC + HALF + 9 * CPB;
  // Ticks from the pin falling to rx_valid being visible
  localparam int VALID_LAT = STOP_TICK + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  logic [7:0] exp_rdata = 8'h00;
  logic       exp_valid = 1'b0;
  int         exp_fe    = 0;
  int         exp_ov    = 0;

  // Count status pulses away from the active edge
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (bus.overrun === 1'b1) ov_cnt <= ov_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Line level 'off' cycles after the start edge, for an ideal frame of bit length L
  function automatic logic line_at(input logic [7:0] b, input int L, input logic stop_lvl, input int off);
    int j;
    j = off / L;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9) return stop_lvl;
    return 1'b1;
  endfunction

  // What a receiver sampling at the nominal mid-bit points reads from that frame
  task automatic model_frame(input logic [7:0] b, input int L, input logic stop_lvl,
                             output logic start_ok, output logic [7:0] got, output logic stop_ok);
    start_ok = !line_at(b, L, stop_lvl, HALF);
    for (int k = 0; k < 8; k++) got[k] = line_at(b, L, stop_lvl, HALF + (k + 1) * CPB);
    stop_ok = line_at(b, L, stop_lvl, HALF + 9 * CPB);
  endtask

  task automatic expect_frame(input logic [7:0] b, input int L, input logic stop_lvl, input logic acked);
    logic       s_ok;
    logic       p_ok;
    logic [7:0] got;
    model_frame(b, L, stop_lvl, s_ok, got, p_ok);
    if (s_ok) begin
      if (p_ok) begin
        if (exp_valid && !acked) exp_ov++;
        exp_rdata = got;
        exp_valid = 1'b1;
      end else begin
        exp_fe++;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int L, input logic stop_lvl,
                            input int ack_at, output int rise_t);
    rise_t = -1;
    for (int t = 0; t < 10 * L; t++) begin
      if (rise_t < 0 && bus.rx_valid === 1'b1) rise_t = t;
      rx = line_at(b, L, stop_lvl, t);
      bus.rd_ack = (t == ack_at);
      tick();
    end
    bus.rd_ack = 1'b0;
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic ack_pulse();
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rdata"}, bus.rdata, exp_rdata);
    check({tag, ".rx_valid"}, bus.rx_valid, exp_valid);
    check({tag, ".frame_err_cnt"}, fe_cnt, exp_fe);
    check({tag, ".overrun_cnt"}, ov_cnt, exp_ov);
  endtask

  initial begin
    int         rise;
    logic       busy_hist [16];
    logic [7:0] b;
    int         mode;
    int         gap;

    // Reset values
    bus.rd_ack = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst.rdata", bus.rdata, 8'h00);
    check("rst.rx_valid", bus.rx_valid, 1'b0);
    check("rst.frame_err", bus.frame_err, 1'b0);
    check("rst.overrun", bus.overrun, 1'b0);
    check("rst.rx_busy", bus.rx_busy, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // Ideal frame, exact latency, ack clears, stray ack ignored
    send_frame(8'hA5, CPB, 1'b1, -1, rise);
    expect_frame(8'hA5, CPB, 1'b1, 1'b0);
    check("a5.latency", rise, VALID_LAT);
    idle(4);
    check_state("a5");
    ack_pulse();
    check("a5.ack_clear", bus.rx_valid, exp_valid);
    idle(2);
    ack_pulse();
    check_state("a5.stray_ack");

    // Back-to-back frames without ack -> one overrun
    send_frame(8'h00, CPB, 1'b1, -1, rise);
    expect_frame(8'h00, CPB, 1'b1, 1'b0);
    send_frame(8'hFF, CPB, 1'b1, -1, rise);
    expect_frame(8'hFF, CPB, 1'b1, 1'b0);
    idle(8);
    check_state("b2b");
    ack_pulse();

    // 4-cycle glitch: busy from START entry until the start sample only
    for (int t = 0; t < 16; t++) begin
      busy_hist[t] = bus.rx_busy;
      rx = (t < 4) ? 1'b0 : 1'b1;
      tick();
    end
    check("glitch.busy_before", busy_hist[SYNC], 1'b0);
    check("glitch.busy_start", busy_hist[SYNC + 1], 1'b1);
    check("glitch.busy_sample", busy_hist[SYNC + HALF], 1'b1);
    check("glitch.busy_idle", busy_hist[SYNC + HALF + 1], 1'b0);
    check_state("glitch");

    // Stop bit low, then a long break: one frame_err, no retrigger
    send_frame(8'h3C, CPB, 1'b0, -1, rise);
    expect_frame(8'h3C, CPB, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40 * CPB) tick();
    check("brk.busy_low", bus.rx_busy, 1'b1);
    check_state("brk.low");
    rx = 1'b1;
    repeat (SYNC + 1) tick();
    check("brk.busy_idle", bus.rx_busy, 1'b0);
    check_state("brk.high");

    // Skewed bit periods; the model derives which line bit each sample lands in
    send_frame(8'h5A, 17, 1'b1, -1, rise);
    expect_frame(8'h5A, 17, 1'b1, 1'b0);
    idle(12);
    check_state("slow17");
    ack_pulse();
    send_frame(8'h5A, 15, 1'b1, -1, rise);
    expect_frame(8'h5A, 15, 1'b1, 1'b0);
    idle(12);
    check_state("fast15");
    ack_pulse();

    // Ack in the very cycle a byte completes: no overrun, valid stays high
    send_frame(8'h42, CPB, 1'b1, -1, rise);
    expect_frame(8'h42, CPB, 1'b1, 1'b0);
    send_frame(8'h99, CPB, 1'b1, STOP_TICK, rise);
    expect_frame(8'h99, CPB, 1'b1, 1'b1);
    idle(4);
    check_state("ack_same");

    // Random bytes with random ack behaviour and gaps
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 20));
      send_frame(b, CPB, 1'b1, (mode == 2) ? STOP_TICK : -1, rise);
      expect_frame(b, CPB, 1'b1, mode == 2);
      idle(gap);
      check_state($sformatf("rnd%0d", i));
      if (mode == 1) begin
        ack_pulse();
        check($sformatf("rnd%0d.ack", i), bus.rx_valid, exp_valid);
      end
    end

    // Reset during data bit 4 discards the frame
    send_frame(8'h7E, CPB, 1'b1, -1, rise);
    expect_frame(8'h7E, CPB, 1'b1, 1'b0);
    for (int t = 0; t < 86; t++) begin
      rx = line_at(8'hC3, CPB, 1'b1, t);
      tick();
    end
    check("mid.busy", bus.rx_busy, 1'b1);
    rst_n = 1'b0;
    rx = 1'b1;
    tick();
    check("mid_rst.rdata", bus.rdata, 8'h00);
    check("mid_rst.rx_valid", bus.rx_valid, 1'b0);
    check("mid_rst.frame_err", bus.frame_err, 1'b0);
    check("mid_rst.overrun", bus.overrun, 1'b0);
    check("mid_rst.rx_busy", bus.rx_busy, 1'b0);
    tick();
    rst_n = 1'b1;
    exp_rdata = 8'h00;
    exp_valid = 1'b0;
    idle(20);
    check_state("post_rst");
    send_frame(8'h81, CPB, 1'b1, -1, rise);
    expect_frame(8'h81, CPB, 1'b1, 1'b0);
    idle(4);
    check_state("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
